// File: rtl/rst_seq_if.sv
// ---------------------------------------------------------------------------
// rst_seq_if
// Reset request / reset distribution bundle for one clock domain.
//   ext_rst_i  asynchronous external reset request (active-high level)
//   sw_rst_i   synchronous software reset request (active-high pulse)
//   rst_o      per-channel reset, active-high
//   rst_n_o    per-channel reset, active-low (inverse of rst_o)
//   busy_o     release sequence still in progress
//   done_o     every channel released
// Modports:
//   master  the requester / consumer of the domain resets
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface rst_seq_if #(
  parameter int unsigned N_CH = 4
);

  logic            ext_rst_i;
  logic            sw_rst_i;
  logic [N_CH-1:0] rst_o;
  logic [N_CH-1:0] rst_n_o;
  logic            busy_o;
  logic            done_o;

  modport master (
    output ext_rst_i,
    output sw_rst_i,
    input  rst_o,
    input  rst_n_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  ext_rst_i,
    input  sw_rst_i,
    output rst_o,
    output rst_n_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq
// Multi-channel reset sequencer for a single clock domain. Synchronises the
// external reset request, merges it with the software reset pulse, holds all
// channels in reset for HOLD_CYC trigger-free cycles, then releases channel 0
// first and each following channel GAP_CYC cycles later.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high master reset
//   seq_if  rst_seq_if.slave bundle:
//             ext_rst_i, sw_rst_i  (requests in)
//             rst_o, rst_n_o, busy_o, done_o  (registered outputs)
// ---------------------------------------------------------------------------
module rst_seq #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  rst_seq_if.slave  seq_if
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam int unsigned IDX_W  = $clog2(N_CH + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Synchroniser chain; last stage is the usable request
  logic [SYNC_STAGES-1:0] r_sync;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [N_CH-1:0]   r_rst;
  logic [N_CH-1:0]   w_rst_nxt;
  logic [N_CH-1:0]   r_rst_n;
  logic [N_CH-1:0]   w_rst_n_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;

  logic              w_ext_sync;
  logic              w_trigger;
  logic              w_restart;

  // External request synchroniser; resets to "request asserted"
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], seq_if.ext_rst_i};
    end
  end

  assign w_ext_sync = r_sync[SYNC_STAGES-1];
  assign w_trigger  = w_ext_sync | seq_if.sw_rst_i;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_HOLD;
      r_hold  <= '0;
      r_gap   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_gap   <= w_gap_nxt;
      r_idx   <= w_idx_nxt;
      r_rst   <= w_rst_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_gap_nxt   = r_gap;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_restart   = 1'b0;

    unique case (r_state)
      ST_HOLD: begin
        w_rst_nxt  = '1;
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
        if (w_trigger) begin
          w_hold_nxt = '0;
        end else if (r_hold == HOLD_LAST) begin
          w_hold_nxt = '0;
          w_gap_nxt  = '0;
          if (N_CH == 1) begin
            // Only one channel: its release completes the sequence
            w_state_nxt = ST_DONE;
            w_rst_nxt   = '0;
            w_idx_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_RELEASE;
            w_rst_nxt[0] = 1'b0;
            w_idx_nxt    = IDX_W'(1);
          end
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        // A trigger always wins over a release due on the same edge
        if (w_trigger) begin
          w_restart = 1'b1;
        end else if (r_gap == GAP_LAST) begin
          w_gap_nxt = '0;
          for (int unsigned i = 0; i < N_CH; i++) begin
            if (r_idx == IDX_W'(i)) begin
              w_rst_nxt[i] = 1'b0;
            end
          end
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end

      ST_DONE: begin
        w_hold_nxt = '0;
        if (w_trigger) begin
          w_restart = 1'b1;
        end
      end

      default: begin
        w_restart = 1'b1;
      end
    endcase

    // Return to a full hold with every channel asserted
    if (w_restart) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = '0;
      w_gap_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
    end

    w_rst_n_nxt = ~w_rst_nxt;
  end

  assign seq_if.rst_o   = r_rst;
  assign seq_if.rst_n_o = r_rst_n;
  assign seq_if.busy_o  = r_busy;
  assign seq_if.done_o  = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq
// Drives two sequencers (default parameters and a minimal configuration)
// from shared stimulus and compares them every cycle against a reference
// built from release rules: a channel count derived from the number of
// trigger-free edges since the last trigger.
// ---------------------------------------------------------------------------
module tb_rst_seq;

  localparam int A_N = 4;
  localparam int A_S = 2;
  localparam int A_H = 16;
  localparam int A_G = 4;
  localparam int B_N = 1;
  localparam int B_S = 3;
  localparam int B_H = 1;
  localparam int B_G = 1;

  logic clk = 1'b0;
  logic tb_rst;
  logic tb_ext;
  logic tb_sw;

  int n_checks = 0;
  int n_fail   = 0;

  rst_seq_if #(.N_CH(A_N)) a_if ();
  rst_seq_if #(.N_CH(B_N)) b_if ();

  assign a_if.ext_rst_i = tb_ext;
  assign a_if.sw_rst_i  = tb_sw;
  assign b_if.ext_rst_i = tb_ext;
  assign b_if.sw_rst_i  = tb_sw;

  rst_seq #(
    .N_CH(A_N), .SYNC_STAGES(A_S), .HOLD_CYC(A_H), .GAP_CYC(A_G)
  ) u_a (
    .clk_i (clk),
    .rst_i (tb_rst),
    .seq_if(a_if)
  );

  rst_seq #(
    .N_CH(B_N), .SYNC_STAGES(B_S), .HOLD_CYC(B_H), .GAP_CYC(B_G)
  ) u_b (
    .clk_i (clk),
    .rst_i (tb_rst),
    .seq_if(b_if)
  );

  always #5 clk = ~clk;

  // Reference: ext request delayed by S edges (reset fills with 1s), and a
  // count of consecutive trigger-free edges since the last trigger/reset.
  bit qa[$];
  bit qb[$];
  int ca;
  int cb;

  always @(posedge clk) begin : model
    bit old_a;
    bit old_b;
    if (tb_rst) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < A_S; i++) qa.push_back(1'b1);
      for (int i = 0; i < B_S; i++) qb.push_back(1'b1);
      ca = 0;
      cb = 0;
    end else begin
      old_a = qa.pop_front();
      old_b = qb.pop_front();
      qa.push_back(tb_ext);
      qb.push_back(tb_ext);
      if (old_a || tb_sw) ca = 0;
      else if (ca < 100000) ca = ca + 1;
      if (old_b || tb_sw) cb = 0;
      else if (cb < 100000) cb = cb + 1;
    end
  end

  // Channels released after c trigger-free edges
  function automatic int released(input int c, input int h, input int g, input int n);
    int r;
    if (c < h) return 0;
    r = 1 + (c - h) / g;
    return (r > n) ? n : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [A_N-1:0] ea;
    logic [A_N-1:0] na;
    logic [B_N-1:0] eb;
    logic [B_N-1:0] nb;
    logic           da;
    logic           db;
    int ra;
    int rb;
    ra = released(ca, A_H, A_G, A_N);
    rb = released(cb, B_H, B_G, B_N);
    for (int i = 0; i < A_N; i++) ea[i] = (i >= ra);
    for (int i = 0; i < B_N; i++) eb[i] = (i >= rb);
    na = ~ea;
    nb = ~eb;
    da = (ra == A_N);
    db = (rb == B_N);
    chk("a_rst_o",   a_if.rst_o,   ea);
    chk("a_rst_n_o", a_if.rst_n_o, na);
    chk("a_done_o",  a_if.done_o,  da);
    chk("a_busy_o",  a_if.busy_o,  !da);
    chk("b_rst_o",   b_if.rst_o,   eb);
    chk("b_rst_n_o", b_if.rst_n_o, nb);
    chk("b_done_o",  b_if.done_o,  db);
    chk("b_busy_o",  b_if.busy_o,  !db);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_a_rst(input logic [A_N-1:0] pat, input int limit, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      if (a_if.rst_o === pat) found = 1'b1;
      else tick();
    end
    chk(tag, found, 1);
  endtask

  initial begin
    tb_rst = 1'b1;
    tb_ext = 1'b0;
    tb_sw  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_state_rst_o",   a_if.rst_o,   4'hF);
    chk("rst_state_rst_n_o", a_if.rst_n_o, 4'h0);
    chk("rst_state_busy",    a_if.busy_o,  1);
    chk("rst_state_done",    a_if.done_o,  0);
    tb_rst = 1'b0;

    // Power-up release schedule
    for (int n = 1; n <= 32; n++) begin
      tick();
      case (n)
        3:  begin chk("pu_b_e3_rst", b_if.rst_o, 1); chk("pu_b_e3_done", b_if.done_o, 0); end
        4:  begin chk("pu_b_e4_rst", b_if.rst_o, 0); chk("pu_b_e4_done", b_if.done_o, 1); end
        17: chk("pu_e17", a_if.rst_o, 4'b1111);
        18: chk("pu_e18", a_if.rst_o, 4'b1110);
        22: chk("pu_e22", a_if.rst_o, 4'b1100);
        26: chk("pu_e26", a_if.rst_o, 4'b1000);
        29: chk("pu_e29_done", a_if.done_o, 0);
        30: begin chk("pu_e30", a_if.rst_o, 4'b0000); chk("pu_e30_done", a_if.done_o, 1); end
        default: ;
      endcase
    end

    // One-cycle external glitch while DONE
    tb_ext = 1'b1;
    tick();
    tb_ext = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      case (n)
        1:  chk("ext_e1_done", a_if.done_o, 1);
        2:  begin chk("ext_e2_rst", a_if.rst_o, 4'hF); chk("ext_e2_done", a_if.done_o, 0); end
        17: chk("ext_e17", a_if.rst_o, 4'b1111);
        18: chk("ext_e18", a_if.rst_o, 4'b1110);
        22: chk("ext_e22", a_if.rst_o, 4'b1100);
        29: chk("ext_e29_done", a_if.done_o, 0);
        30: chk("ext_e30_done", a_if.done_o, 1);
        default: ;
      endcase
    end

    // Software pulse while DONE
    tb_sw = 1'b1;
    tick();
    tb_sw = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      case (n)
        1:  chk("sw_t1", a_if.rst_o, 4'hF);
        15: chk("sw_t15_ch0", a_if.rst_o[0], 1);
        16: chk("sw_t16_ch0", a_if.rst_o[0], 0);
        27: chk("sw_t27_done", a_if.done_o, 0);
        28: chk("sw_t28_done", a_if.done_o, 1);
        default: ;
      endcase
    end

    // Hold restart: second pulse when the hold count has reached 10
    tb_sw = 1'b1;
    tick();
    tb_sw = 1'b0;
    repeat (10) tick();
    tb_sw = 1'b1;
    tick();
    tb_sw = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      case (n)
        15: chk("hold_t15", a_if.rst_o, 4'b1111);
        16: chk("hold_t16", a_if.rst_o, 4'b1110);
        default: ;
      endcase
    end

    // Abort mid-release by software trigger, then by master reset
    wait_a_rst(4'b1100, 20, "wait_1100_a");
    tb_sw = 1'b1;
    tick();
    tb_sw = 1'b0;
    chk("abort_sw_rst", a_if.rst_o, 4'hF);
    chk("abort_sw_done", a_if.done_o, 0);
    wait_a_rst(4'b1100, 40, "wait_1100_b");
    tb_rst = 1'b1;
    tick();
    tb_rst = 1'b0;
    chk("abort_rst_rst", a_if.rst_o, 4'hF);
    chk("abort_rst_busy", a_if.busy_o, 1);
    chk("abort_rst_done", a_if.done_o, 0);

    // Randomised requests
    for (int n = 0; n < 400; n++) begin
      tb_ext = ($urandom_range(0, 24) == 0);
      tb_sw  = ($urandom_range(0, 39) == 0);
      tb_rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    tb_ext = 1'b0;
    tb_sw  = 1'b0;
    tb_rst = 1'b0;
    repeat (40) tick();
    chk("final_done", a_if.done_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised multi-channel reset sequencer for one clock domain, successor to the single-output two-flop reset synchroniser.
- Synchronises an asynchronous external reset request and merges it with a software reset pulse.
- Enforces a minimum reset hold time, then releases N_CH downstream resets in ascending order, spaced GAP_CYC cycles apart.
- Sits at the top of each clock domain (clk_div and peripherals) and drives every block reset in that domain.

Parameters:
- N_CH, 4, number of reset output channels (>=1); channel 0 is released first.
- SYNC_STAGES, 2, flops in the ext_rst_i synchroniser chain (>=2).
- HOLD_CYC, 16, consecutive trigger-free cycles required before the first release (>=1).
- GAP_CYC, 4, cycles between successive channel releases (>=1).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high master reset.
- ext_rst_i  input  1  asynchronous external reset request, active-high, level.
- sw_rst_i  input  1  synchronous software reset request, active-high; a 1-cycle pulse is sufficient.
- rst_o  output  N_CH  per-channel reset, active-high.
- rst_n_o  output  N_CH  bitwise inverse of rst_o, registered alongside it.
- busy_o  output  1  high while the sequence is not complete.
- done_o  output  1  high once all channels are released.

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (rst_i=1 at an edge) sets:
  - synchroniser chain all 1s (request asserted);
  - state HOLD, hold counter 0, gap counter 0, channel index 0;
  - rst_o all 1s, rst_n_o all 0s, busy_o=1, done_o=0.
- Synchroniser: ext_rst_i shifts through SYNC_STAGES flops; ext_sync is the last stage. Latency is SYNC_STAGES edges.
- trigger = ext_sync OR sw_rst_i, evaluated from pre-edge values.
- HOLD:
  - rst_o all 1s.
  - trigger=1: hold counter cleared to 0.
  - Otherwise the hold counter increments.
  - Hold counter == HOLD_CYC-1 and trigger=0: on that edge go to RELEASE, clear rst_o[0], gap counter=0, index=1.
  - If N_CH==1, go straight to DONE on that edge instead.
- RELEASE:
  - Gap counter increments each edge.
  - Gap counter == GAP_CYC-1: clear rst_o[index], gap counter=0, index+1.
  - Releasing channel N_CH-1 moves to DONE on the same edge: done_o=1, busy_o=0.
- DONE: holds all outputs; hold counter stays 0.
- Trigger in RELEASE or DONE:
  - Next edge: state HOLD, rst_o all 1s, done_o=0, busy_o=1, counters and index to 0.
  - Full HOLD_CYC hold applies again; trigger always beats a pending release on the same edge.
- Sustained trigger in HOLD keeps the hold counter at 0; rst_o stays asserted indefinitely.
- Release timing after rst_i deasserts, with ext_rst_i=0 and no sw_rst_i (edge 1 = first edge sampling rst_i=0):
  - rst_o[k] clears at edge SYNC_STAGES+HOLD_CYC+k*GAP_CYC.
  - done_o rises with the release of the last channel.
- Release timing after a sw_rst_i pulse sampled at edge t, in any state: rst_o[0] clears at edge t+HOLD_CYC.
- rst_i asserted mid-sequence: full reset state on that edge, regardless of state.
- Release order is monotonic: rst_o[j] is never 0 while rst_o[i] is 1 for any i<j.
- Counter widths: $clog2(HOLD_CYC+1), $clog2(GAP_CYC+1), $clog2(N_CH+1).

Test Plan:
- Power-up, defaults: rst_i high 3 cycles then low, ext_rst_i=0 -> rst_o=4'b1111 until edge 18, 4'b1110 at 18, 4'b1100 at 22, 4'b1000 at 26, 4'b0000 plus done_o=1 at 30; rst_n_o always equals ~rst_o.
- ext_rst_i glitch: ext_rst_i high for 1 cycle in DONE -> rst_o=4'b1111 and done_o=0 SYNC_STAGES+1 edges later; full sequence repeats with the same 16/4 spacing.
- Software pulse: sw_rst_i 1-cycle pulse at edge t in DONE -> rst_o=1111 at t+1, rst_o[0]=0 at t+16, done_o at t+28.
- Hold restart: sw_rst_i pulses during HOLD when hold count is 10 -> count restarts; first release is 16 edges after the pulse edge.
- Mid-release abort: trigger while rst_o=4'b1100 -> all 1s next edge; rst_i mid-release -> all 1s on the same edge.
- Parameter sweep: N_CH=1, HOLD_CYC=1, GAP_CYC=1, SYNC_STAGES=3 -> rst_o clears and done_o=1 at edge 4.
